// File: rtl/alk_pkg.sv
// Shared encodings for the carry lookahead / condition-code stage.
package alk_pkg;

  localparam int SLICES = 8;

  // Active data size; any value with bit 1 set selects long.
  typedef enum logic [1:0] {
    DSZ_BYTE = 2'b00,
    DSZ_WORD = 2'b01,
    DSZ_LONG = 2'b10
  } d_size_e;

  // PSL condition-code operation.
  typedef enum logic [2:0] {
    CCOP_HOLD = 3'b000,
    CCOP_ALU  = 3'b001,
    CCOP_NZ   = 3'b010,
    CCOP_WR   = 3'b011,
    CCOP_CLR  = 3'b100
  } cc_op_e;

  // Carry-in source for slice 0.
  typedef enum logic [1:0] {
    CIN_ZERO  = 2'b00,
    CIN_ONE   = 2'b01,
    CIN_LAT   = 2'b10,
    CIN_NLAT  = 2'b11
  } cin_sel_e;

  // Bit positions inside an {N,Z,V,C} nibble.
  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

endpackage

// File: rtl/alk_cla.sv
// Combinational 8-slice carry lookahead. Slice terms arrive active-low;
// the chain is evaluated active-high and returned as active-low carry-in.
module alk_cla
  import alk_pkg::*;
(
  input  logic [SLICES-1:0] p_l,
  input  logic [SLICES-1:0] g_l,
  input  logic              cin,
  output logic [SLICES-1:0] aluc_l,
  output logic [SLICES:0]   c
);

  logic [SLICES-1:0] p;
  logic [SLICES-1:0] g;

  assign p = ~p_l;
  assign g = ~g_l;

  // Carry chain: c[i+1] = g[i] | p[i] & c[i]
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < SLICES; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign aluc_l = ~c[SLICES-1:0];

endmodule

// File: rtl/alk_ccode.sv
// Carry lookahead and condition-code stage behind the ALP bitslice array.
// Optional step counter is built only when ALK_STEP_COUNTER_EN is defined;
// otherwise cnt_zero_h is tied high and the counter inputs are ignored.
module alk_ccode
  import alk_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic [7:0]       p_l,
  input  logic [7:0]       g_l,
  output logic [7:0]       aluc_l,
  input  logic [1:0]       cin_sel_h,
  input  logic             sub_h,
  input  logic [1:0]       d_size_h,
  input  logic [3:0]       wmuxz_h,
  input  logic [3:0]       aluv_h,
  input  logic [3:0]       sign_h,
  input  logic [3:0]       psl_wr_h,
  input  logic [2:0]       cc_op_h,
  input  logic             ucc_ld_h,
  input  logic             cy_ld_h,
  input  logic             cnt_ld_h,
  input  logic [CNT_W-1:0] cnt_val_h,
  input  logic             cnt_dec_h,
  output logic [3:0]       alu_nzvc_h,
  output logic [3:0]       psl_cc_h,
  output logic [3:0]       ucc_h,
  output logic             c_lat_h,
  output logic             cnt_zero_h
);

  logic       cin;
  logic [8:0] c;
  logic       cout;
  logic       flag_n, flag_z, flag_v, flag_c;
  logic [3:0] psl_q, psl_d;
  logic [3:0] ucc_q, ucc_d;
  logic       c_lat_q, c_lat_d;

  // Carry-in source select
  always_comb begin
    cin = 1'b0;
    case (cin_sel_e'(cin_sel_h))
      CIN_ZERO: cin = 1'b0;
      CIN_ONE:  cin = 1'b1;
      CIN_LAT:  cin = c_lat_q;
      CIN_NLAT: cin = ~c_lat_q;
      default:  cin = 1'b0;
    endcase
  end

  alk_cla u_cla (
    .p_l    (p_l),
    .g_l    (g_l),
    .cin    (cin),
    .aluc_l (aluc_l),
    .c      (c)
  );

  // Intermediate carries are consumed only through aluc_l.
  logic unused_c;
  assign unused_c = ^{c[7:5], c[3], c[1:0]};

  // Size-dependent flag selection
  always_comb begin
    if (d_size_h[1]) begin
      cout   = c[8];
      flag_n = sign_h[3];
      flag_z = &wmuxz_h;
      flag_v = aluv_h[3];
    end else if (d_size_h[0]) begin
      cout   = c[4];
      flag_n = sign_h[1];
      flag_z = &wmuxz_h[1:0];
      flag_v = aluv_h[1];
    end else begin
      cout   = c[2];
      flag_n = sign_h[0];
      flag_z = wmuxz_h[0];
      flag_v = aluv_h[0];
    end
    flag_c = cout ^ sub_h;
  end

  assign alu_nzvc_h = {flag_n, flag_z, flag_v, flag_c};

  // PSL / microcode CC / multi-precision carry next-state
  always_comb begin
    psl_d = psl_q;
    case (cc_op_e'(cc_op_h))
      CCOP_HOLD: psl_d = psl_q;
      CCOP_ALU:  psl_d = alu_nzvc_h;
      CCOP_NZ:   psl_d = {flag_n, flag_z, 1'b0, psl_q[CC_C]};
      CCOP_WR:   psl_d = psl_wr_h;
      CCOP_CLR:  psl_d = 4'b0000;
      default:   psl_d = psl_q;
    endcase
    ucc_d   = ucc_ld_h ? alu_nzvc_h : ucc_q;
    c_lat_d = cy_ld_h ? flag_c : c_lat_q;
  end

  // Condition-code registers
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      psl_q   <= 4'b0000;
      ucc_q   <= 4'b0000;
      c_lat_q <= 1'b0;
    end else begin
      psl_q   <= psl_d;
      ucc_q   <= ucc_d;
      c_lat_q <= c_lat_d;
    end
  end

  assign psl_cc_h = psl_q;
  assign ucc_h    = ucc_q;
  assign c_lat_h  = c_lat_q;

`ifdef ALK_STEP_COUNTER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Step counter next-state: load wins, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_ld_h) begin
      cnt_d = cnt_val_h;
    end else if (cnt_dec_h && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Step counter register
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero_h = (cnt_q == '0);
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_ld_h, cnt_dec_h, cnt_val_h};
  assign cnt_zero_h = 1'b1;
`endif

endmodule

// File: tb/tb_alk_ccode.sv
// Directed bench for alk_ccode: lookahead, flag select, CC ops, carry latch,
// and the optional step counter.
module tb_alk_ccode;

  logic       clk_h = 1'b0;
  logic       rst_h;
  logic [7:0] p_l, g_l, aluc_l;
  logic [1:0] cin_sel_h, d_size_h;
  logic       sub_h;
  logic [3:0] wmuxz_h, aluv_h, sign_h, psl_wr_h;
  logic [2:0] cc_op_h;
  logic       ucc_ld_h, cy_ld_h, cnt_ld_h, cnt_dec_h;
  logic [4:0] cnt_val_h;
  logic [3:0] alu_nzvc_h, psl_cc_h, ucc_h;
  logic       c_lat_h, cnt_zero_h;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_h = ~clk_h;

  alk_ccode #(.CNT_W(5)) dut (
    .clk_h(clk_h), .rst_h(rst_h), .p_l(p_l), .g_l(g_l), .aluc_l(aluc_l),
    .cin_sel_h(cin_sel_h), .sub_h(sub_h), .d_size_h(d_size_h),
    .wmuxz_h(wmuxz_h), .aluv_h(aluv_h), .sign_h(sign_h), .psl_wr_h(psl_wr_h),
    .cc_op_h(cc_op_h), .ucc_ld_h(ucc_ld_h), .cy_ld_h(cy_ld_h),
    .cnt_ld_h(cnt_ld_h), .cnt_val_h(cnt_val_h), .cnt_dec_h(cnt_dec_h),
    .alu_nzvc_h(alu_nzvc_h), .psl_cc_h(psl_cc_h), .ucc_h(ucc_h),
    .c_lat_h(c_lat_h), .cnt_zero_h(cnt_zero_h)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  // Drop all one-cycle strobes.
  task automatic idle();
    cc_op_h = 3'b000; ucc_ld_h = 0; cy_ld_h = 0; cnt_ld_h = 0; cnt_dec_h = 0;
  endtask

  initial begin
    rst_h = 1; p_l = 8'hFF; g_l = 8'hFF; cin_sel_h = 0; sub_h = 0; d_size_h = 2'b10;
    wmuxz_h = 0; aluv_h = 0; sign_h = 0; psl_wr_h = 0; cnt_val_h = 0;
    idle();
    tick(); tick();
    rst_h = 0;
    #1;
    chk("rst_psl", {4'h0, psl_cc_h}, 8'h00);
    chk("rst_ucc", {4'h0, ucc_h}, 8'h00);
    chk("rst_clat", {7'h0, c_lat_h}, 8'h00);
    chk("rst_cntz", {7'h0, cnt_zero_h}, 8'h01);

    // Lookahead ripple through all propagating slices
    p_l = 8'h00; g_l = 8'hFF; cin_sel_h = 2'd1; d_size_h = 2'b10; #1;
    chk("ripple_cin1_aluc", aluc_l, 8'h00);
    chk("ripple_cin1_C", {7'h0, alu_nzvc_h[0]}, 8'h01);
    cin_sel_h = 2'd0; #1;
    chk("ripple_cin0_aluc", aluc_l, 8'hFF);
    chk("ripple_cin0_C", {7'h0, alu_nzvc_h[0]}, 8'h00);

    // Size select: slice 1 generates, nothing propagates
    p_l = 8'hFF; g_l = 8'hFD; cin_sel_h = 2'd0; #1;
    chk("gen1_aluc", aluc_l, 8'hFB);
    chk("gen1_long_C", {7'h0, alu_nzvc_h[0]}, 8'h00);
    d_size_h = 2'b11; #1;
    chk("gen1_long11_C", {7'h0, alu_nzvc_h[0]}, 8'h00);
    d_size_h = 2'b00; #1;
    chk("gen1_byte_C", {7'h0, alu_nzvc_h[0]}, 8'h01);
    sub_h = 1; #1;
    chk("gen1_byte_sub_C", {7'h0, alu_nzvc_h[0]}, 8'h00);
    sub_h = 0;

    // Zero / sign / overflow selection
    wmuxz_h = 4'b0011; sign_h = 4'b0010; aluv_h = 4'b0010; d_size_h = 2'b01; #1;
    chk("word_NZV", {5'h0, alu_nzvc_h[3:1]}, 8'h07);
    d_size_h = 2'b10; #1;
    chk("long_NZV", {5'h0, alu_nzvc_h[3:1]}, 8'h00);
    d_size_h = 2'b00; wmuxz_h = 4'b0001; sign_h = 4'b0001; aluv_h = 4'b0001; #1;
    chk("byte_NZV", {5'h0, alu_nzvc_h[3:1]}, 8'h07);

    // Long flags NZVC = 1011
    d_size_h = 2'b10; p_l = 8'h00; g_l = 8'hFF; cin_sel_h = 2'd1;
    sign_h = 4'b1000; wmuxz_h = 4'b0111; aluv_h = 4'b1000; #1;
    chk("long_nzvc", {4'h0, alu_nzvc_h}, 8'h0B);

    cc_op_h = 3'b001; tick();
    chk("ccop_alu", {4'h0, psl_cc_h}, 8'h0B);
    cc_op_h = 3'b010; tick();
    chk("ccop_nz", {4'h0, psl_cc_h}, 8'h09);
    cc_op_h = 3'b011; psl_wr_h = 4'b0110; tick();
    chk("ccop_wr", {4'h0, psl_cc_h}, 8'h06);
    cc_op_h = 3'b101; tick();
    chk("ccop_rsvd_hold", {4'h0, psl_cc_h}, 8'h06);
    cc_op_h = 3'b000; tick();
    chk("ccop_hold", {4'h0, psl_cc_h}, 8'h06);
    cc_op_h = 3'b100; tick();
    chk("ccop_clr", {4'h0, psl_cc_h}, 8'h00);
    idle();

    // Microcode CC and multi-precision carry, loaded together
    ucc_ld_h = 1; cy_ld_h = 1; tick();
    idle();
    chk("ucc_ld", {4'h0, ucc_h}, 8'h0B);
    chk("clat_ld", {7'h0, c_lat_h}, 8'h01);
    chk("psl_untouched", {4'h0, psl_cc_h}, 8'h00);
    cin_sel_h = 2'd2; #1;
    chk("cin_lat_aluc0", {7'h0, aluc_l[0]}, 8'h00);
    cin_sel_h = 2'd3; #1;
    chk("cin_nlat_aluc0", {7'h0, aluc_l[0]}, 8'h01);
    tick();
    chk("clat_hold", {7'h0, c_lat_h}, 8'h01);
    // Subtract with carry-out 1 latches borrow 0
    cin_sel_h = 2'd1; sub_h = 1; cy_ld_h = 1; tick();
    idle(); sub_h = 0;
    chk("clat_borrow", {7'h0, c_lat_h}, 8'h00);

`ifdef ALK_STEP_COUNTER_EN
    cnt_val_h = 5'd3; cnt_ld_h = 1; tick(); idle();
    chk("cnt_ld3", {7'h0, cnt_zero_h}, 8'h00);
    cnt_dec_h = 1; tick();
    chk("cnt_dec1", {7'h0, cnt_zero_h}, 8'h00);
    tick();
    chk("cnt_dec2", {7'h0, cnt_zero_h}, 8'h00);
    tick();
    chk("cnt_dec3", {7'h0, cnt_zero_h}, 8'h01);
    tick();
    chk("cnt_dec_sat", {7'h0, cnt_zero_h}, 8'h01);
    // Load beats decrement in the same cycle
    cnt_ld_h = 1; cnt_dec_h = 1; cnt_val_h = 5'd3; tick();
    cnt_ld_h = 0;
    chk("cnt_ld_prio", {7'h0, cnt_zero_h}, 8'h00);
    tick(); tick();
    chk("cnt_ld_prio_2", {7'h0, cnt_zero_h}, 8'h00);
    tick();
    chk("cnt_ld_prio_3", {7'h0, cnt_zero_h}, 8'h01);
    idle();
    cnt_val_h = 5'd3; cnt_ld_h = 1; tick(); idle();
    cnt_dec_h = 1; tick();
`else
    cnt_val_h = 5'd3; cnt_ld_h = 1; tick(); idle();
    chk("cnt_absent_ld", {7'h0, cnt_zero_h}, 8'h01);
    cnt_dec_h = 1; tick();
`endif

    // Reset mid-sequence overrides every load in that cycle
    cin_sel_h = 2'd1; ucc_ld_h = 1; cy_ld_h = 1;
    cc_op_h = 3'b011; psl_wr_h = 4'b1111; cnt_ld_h = 1; cnt_val_h = 5'd7;
    rst_h = 1; tick();
    rst_h = 0; idle();
    chk("rst_mid_psl", {4'h0, psl_cc_h}, 8'h00);
    chk("rst_mid_ucc", {4'h0, ucc_h}, 8'h00);
    chk("rst_mid_clat", {7'h0, c_lat_h}, 8'h00);
    chk("rst_mid_cntz", {7'h0, cnt_zero_h}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
